// File: rtl/ddr_rd_sched_pkg.sv
// rtl/ddr_rd_sched_pkg.sv - shared FSM states, requester indices and beat sizing for ddr_rd_sched
package ddr_rd_sched_pkg;

  typedef enum logic [2:0] {IDLE, CFG_AR, CFG_R, ARB, AR, DATA} state_t;

  localparam int ACT    = 0;
  localparam int FLGACT = 1;
  localparam int WEI    = 2;
  localparam int FLGWEI = 3;

  localparam int PORT_DATAWIDTH_DEF = 128;
  localparam int BYTES              = PORT_DATAWIDTH_DEF / 8;

  // Bytes per beat for a non-default beat width.
  function automatic int beat_bytes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ddr_rd_sched_rr_arb.sv
// rtl/ddr_rd_sched_rr_arb.sv - round-robin arbiter; search begins at ptr and wraps to 0
module rr_arb
  import ddr_rd_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_rd_sched.sv
// rtl/ddr_rd_sched.sv - DDR read scheduler: RR arbitration over requesters, one AXI read in flight.
// Config-word fetch at layer start is built only with DDR_RD_SCHED_CFG_FETCH_EN defined.
module ddr_rd_sched
  import ddr_rd_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int PORT_DATAWIDTH = 128,
  parameter int LEN_WIDTH      = 8,
  parameter int NUM_REQ        = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           stop,
  input  logic [ADDR_WIDTH-1:0]          cfg_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  base_addr,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rd_vld,
  output logic [PORT_DATAWIDTH-1:0]      rd_data,
  output logic                           rd_last,
  output logic [PORT_DATAWIDTH-1:0]      cfg_word,
  output logic                           cfg_vld,
  output logic                           busy,
  output logic                           err,
  output logic                           ar_valid,
  input  logic                           ar_ready,
  output logic [ADDR_WIDTH-1:0]          ar_addr,
  output logic [LEN_WIDTH-1:0]           ar_len,
  input  logic                           r_valid,
  output logic                           r_ready,
  input  logic [PORT_DATAWIDTH-1:0]      r_data,
  input  logic                           r_last
);

  localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_BYTES = beat_bytes(PORT_DATAWIDTH);

  state_t                state;
  logic                  stop_pend;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         gidx;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [ADDR_WIDTH-1:0] offset [NUM_REQ];

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic [LEN_WIDTH-1:0]  arb_len;
  logic [ADDR_WIDTH-1:0] arb_base;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic                  count_done;
  logic                  burst_end;

`ifdef DDR_RD_SCHED_CFG_FETCH_EN
  logic [PORT_DATAWIDTH-1:0] cfg_word_q;
  logic                      cfg_vld_q;
  assign cfg_word = cfg_word_q;
  assign cfg_vld  = cfg_vld_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^cfg_addr;
  assign cfg_word   = '0;
  assign cfg_vld    = 1'b0;
`endif

  rr_arb #(.N(NUM_REQ), .IW(IW)) u_rr_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = IW'(i);
    end
  end

  assign arb_len     = req_len[arb_idx*LEN_WIDTH +: LEN_WIDTH];
  assign arb_base    = base_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
  // Offset step wraps silently at the address width.
  assign burst_bytes = ADDR_WIDTH'((32'(cur_len) + 32'd1) * 32'(BEAT_BYTES));
  assign count_done  = (beat_cnt == cur_len);
  assign burst_end   = (state == DATA) && r_valid && (r_last || count_done);

  assign busy    = (state != IDLE);
  assign r_ready = (state == CFG_R) || (state == DATA);
  assign rd_vld  = (r_valid && state == DATA) ? gnt : '0;
  assign rd_data = r_data;
  assign rd_last = burst_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stop_pend <= 1'b0;
      rr_ptr    <= '0;
      gidx      <= '0;
      cur_len   <= '0;
      beat_cnt  <= '0;
      gnt       <= '0;
      ar_valid  <= 1'b0;
      ar_addr   <= '0;
      ar_len    <= '0;
      err       <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) offset[i] <= '0;
`ifdef DDR_RD_SCHED_CFG_FETCH_EN
      cfg_word_q <= '0;
      cfg_vld_q  <= 1'b0;
`endif
    end else begin
      if (stop && state != IDLE) stop_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_REQ; i++) offset[i] <= '0;
`ifdef DDR_RD_SCHED_CFG_FETCH_EN
            cfg_vld_q <= 1'b0;
            ar_valid  <= 1'b1;
            ar_addr   <= cfg_addr;
            ar_len    <= '0;
            state     <= CFG_AR;
`else
            state     <= ARB;
`endif
          end
        end
        CFG_AR: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            state    <= CFG_R;
          end
        end
        CFG_R: begin
          if (r_valid) begin
`ifdef DDR_RD_SCHED_CFG_FETCH_EN
            cfg_word_q <= r_data;
            cfg_vld_q  <= 1'b1;
`endif
            state <= ARB;
          end
        end
        ARB: begin
          if (stop_pend) begin
            stop_pend <= 1'b0;
            state     <= IDLE;
          end else if (|req) begin
            gnt      <= arb_gnt;
            gidx     <= arb_idx;
            cur_len  <= arb_len;
            ar_len   <= arb_len;
            ar_addr  <= arb_base + offset[arb_idx];
            ar_valid <= 1'b1;
            rr_ptr   <= IW'((int'(arb_idx) + 1) % NUM_REQ);
            state    <= AR;
          end
        end
        AR: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (r_valid) begin
            if (r_last || count_done) begin
              offset[gidx] <= offset[gidx] + burst_bytes;
              // Early r_last and a missing r_last are both flagged.
              if (r_last != count_done) err <= 1'b1;
              gnt      <= '0;
              beat_cnt <= '0;
              if (stop_pend) begin
                stop_pend <= 1'b0;
                state     <= IDLE;
              end else begin
                state <= ARB;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_sched.sv
// tb/tb_ddr_rd_sched.sv - randomized self-checking bench for ddr_rd_sched against an address/grant model
module tb_ddr_rd_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stop;
  logic [31:0]  cfg_addr;
  logic [127:0] base_addr;
  logic [3:0]   req;
  logic [31:0]  req_len;
  logic [3:0]   gnt, rd_vld;
  logic [127:0] rd_data, cfg_word, r_data;
  logic         rd_last, cfg_vld, busy, err;
  logic         ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [31:0]  ar_addr;
  logic [7:0]   ar_len;

  logic [31:0]  base_a [4];
  logic [7:0]   len_a  [4];
  logic [31:0]  off_m  [4];
  int           rr_next;
  logic         err_exp;
  int           checks = 0;
  int           errors = 0;

  assign base_addr = {base_a[3], base_a[2], base_a[1], base_a[0]};
  assign req_len   = {len_a[3], len_a[2], len_a[1], len_a[0]};

  always #5 clk = ~clk;

  ddr_rd_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cfg_addr(cfg_addr),
    .base_addr(base_addr), .req(req), .req_len(req_len), .gnt(gnt), .rd_vld(rd_vld),
    .rd_data(rd_data), .rd_last(rd_last), .cfg_word(cfg_word), .cfg_vld(cfg_vld),
    .busy(busy), .err(err), .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .ar_len(ar_len), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] rq, input int from);
    for (int i = 0; i < 4; i++) if (rq[(from + i) % 4]) return (from + i) % 4;
    return -1;
  endfunction

  task automatic reset_checks();
    check("rst_gnt", gnt, 0);
    check("rst_rd_vld", rd_vld, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_ar_valid", ar_valid, 0);
    check("rst_r_ready", r_ready, 0);
    check("rst_cfg_vld", cfg_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_cfg_word", cfg_word, 0);
    check("rst_ar_addr", ar_addr, 0);
    check("rst_ar_len", ar_len, 0);
  endtask

  task automatic start_layer(input logic [31:0] ca);
    int n;
    @(negedge clk);
    cfg_addr = ca;
    start    = 1'b1;
    for (int i = 0; i < 4; i++) off_m[i] = 32'h0;
    @(negedge clk);
    start = 1'b0;
`ifdef DDR_RD_SCHED_CFG_FETCH_EN
    check("cfg_vld_clr", cfg_vld, 0);
    n = 0;
    while (!ar_valid && n < 50) begin @(negedge clk); n++; end
    check("cfg_ar_seen", ar_valid, 1);
    check("cfg_ar_addr", ar_addr, ca);
    check("cfg_ar_len", ar_len, 0);
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    r_valid  = 1'b1;
    r_last   = 1'b1;
    r_data   = {16{8'hA5}};
    #1;
    check("cfg_r_ready", r_ready, 1);
    check("cfg_rd_vld", rd_vld, 0);
    @(negedge clk);
    r_valid = 1'b0;
    r_last  = 1'b0;
    check("cfg_vld", cfg_vld, 1);
    check("cfg_word", cfg_word, {16{8'hA5}});
`else
    n = 0;
    check("cfg_vld_off", cfg_vld, 0);
    check("cfg_word_off", cfg_word, 0);
    check("busy_after_start", busy, 1);
`endif
  endtask

  // Serves one burst for requester g; last_at = beat carrying r_last, stop_cyc = cycle to pulse stop.
  task automatic run(input int g, input int lenv, input int last_at, input int stop_cyc);
    int n, b, endb;
    logic [31:0] ea;
    len_a[g] = 8'(lenv);
    n = 0;
    while (!ar_valid && n < 50) begin @(negedge clk); n++; end
    check("ar_seen", ar_valid, 1);
    ea = base_a[g] + off_m[g];
    check("ar_addr", ar_addr, ea);
    check("ar_len", ar_len, lenv);
    check("gnt", gnt, 4'b1 << g);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("ar_hold", {ar_valid, ar_len, ar_addr}, {1'b1, 8'(lenv), ea});
    end
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    len_a[g] = 8'($urandom);
    endb = (last_at < lenv) ? last_at : lenv;
    b = 0;
    n = 0;
    while (b <= endb && n < 200) begin
      r_valid = ($urandom_range(0, 3) != 0);
      r_data  = {$urandom, $urandom, $urandom, $urandom};
      r_last  = r_valid && (b == last_at);
      stop    = (n == stop_cyc);
      #1;
      check("r_ready", r_ready, 1);
      check("rd_vld", rd_vld, r_valid ? (4'b1 << g) : 4'b0);
      if (r_valid) begin
        check("rd_data", rd_data, r_data);
        check("rd_last", rd_last, b == endb);
        b++;
      end
      @(negedge clk);
      n++;
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    stop    = 1'b0;
    check("burst_timeout", n < 200, 1);
    if (last_at != lenv) err_exp = 1'b1;
    off_m[g] = off_m[g] + 32'((lenv + 1) * 16);
    rr_next  = (g + 1) % 4;
    check("err", err, err_exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int g, n;
    int lk [4];
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_addr = '0; req = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0; r_data = '0;
    for (int i = 0; i < 4; i++) begin base_a[i] = '0; len_a[i] = '0; off_m[i] = '0; end
    rr_next = 0;
    err_exp = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    start_layer(32'h0);
    base_a[0] = 32'h0010_0000;
    req = 4'b0001;
    run(pick(req, rr_next), 3, 3, -1);
    run(pick(req, rr_next), 3, 3, -1);

    for (int t = 0; t < 30; t++) begin
      req = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        base_a[i] = $urandom & 32'hFFFF_FFF0;
        len_a[i]  = 8'($urandom_range(0, 7));
      end
      g = pick(req, rr_next);
      run(g, int'(len_a[g]), int'(len_a[g]), -1);
    end

    req = 4'b0001;
    run(pick(req, rr_next), 3, 2, -1);

    run(pick(req, rr_next), 3, 3, 1);
    check("stop_busy", busy, 0);
    check("stop_gnt", gnt, 0);
    repeat (3) begin
      @(negedge clk);
      check("idle_no_ar", {busy, ar_valid}, 2'b00);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    start_layer($urandom);
    base_a[2] = 32'hFFFF_FFC0;
    req = 4'b0100;
    run(pick(req, rr_next), 3, 3, -1);
    run(pick(req, rr_next), 3, 3, -1);

    req = 4'b0010;
    len_a[1] = 8'd5;
    n = 0;
    while (!ar_valid && n < 50) begin @(negedge clk); n++; end
    check("mid_ar_seen", ar_valid, 1);
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    r_valid  = 1'b1;
    r_data   = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(negedge clk);
    check("mid_rd_vld", rd_vld, 4'b0010);
    #2 rst_n = 1'b0;
    #1 reset_checks();
    @(negedge clk);
    rst_n   = 1'b1;
    r_valid = 1'b0;
    for (int i = 0; i < 4; i++) off_m[i] = '0;
    rr_next = 0;
    err_exp = 1'b0;

    start_layer(32'h40);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) lk[i] = $urandom_range(0, 3);
    for (int i = 0; i < 5; i++) run(i % 4, lk[i % 4], lk[i % 4], -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
